// File: rtl/brick_move_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// brick_move_ctrl_pkg
// Shared definitions for the active-brick sequencer:
//   - default geometry (coordinate widths, board limit, spawn point)
//   - brick type codes (0 = no brick shown, 1..7 = the seven tetrominoes)
//   - controller state encoding and trial-kind codes
//   - request arbitration helper (drop > rot > left > right > down > gravity)
// A position is packed as {x, y}.
// -----------------------------------------------------------------------------
package brick_move_ctrl_pkg;

    localparam int X_W_DEF     = 4;
    localparam int Y_W_DEF     = 5;
    localparam int X_MAX_DEF   = 11;
    localparam int SPAWN_X_DEF = 6;
    localparam int SPAWN_Y_DEF = 18;
    localparam int DIR_W_DEF   = 2;
    localparam int TYPE_W_DEF  = 3;

    localparam logic [2:0] BRICK_NONE = 3'd0;
    localparam logic [2:0] BRICK_I    = 3'd1;
    localparam logic [2:0] BRICK_O    = 3'd2;
    localparam logic [2:0] BRICK_T    = 3'd3;
    localparam logic [2:0] BRICK_S    = 3'd4;
    localparam logic [2:0] BRICK_Z    = 3'd5;
    localparam logic [2:0] BRICK_J    = 3'd6;
    localparam logic [2:0] BRICK_L    = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_READY = 3'd2,
        ST_CHECK = 3'd3,
        ST_LOCK  = 3'd4,
        ST_CLEAR = 3'd5,
        ST_OVER  = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        K_NONE  = 3'd0,
        K_SPAWN = 3'd1,
        K_LEFT  = 3'd2,
        K_RIGHT = 3'd3,
        K_ROT   = 3'd4,
        K_DOWN  = 3'd5,
        K_DROP  = 3'd6
    } kind_e;

    // One winner per READY cycle; gravity only when no key asks for anything.
    function automatic kind_e pick_request(input logic drop, input logic rot,
                                           input logic left, input logic right,
                                           input logic down, input logic grav);
        kind_e k;
        if (drop)              k = K_DROP;
        else if (rot)          k = K_ROT;
        else if (left)         k = K_LEFT;
        else if (right)        k = K_RIGHT;
        else if (down || grav) k = K_DOWN;
        else                   k = K_NONE;
        return k;
    endfunction

endpackage

// File: rtl/brick_move_ctrl_trial_gen.sv
// -----------------------------------------------------------------------------
// brick_trial_gen
// Combinational trial former. From a base brick placement and a trial kind it
// produces the candidate placement and a forced-collided flag for moves that
// would leave the board (left at x=0, right at x=X_MAX, down/drop at y=0).
// The candidate is still produced (it wraps), but the flag tells the
// controller to treat it as collided regardless of the collision checker.
// Ports:
//   base_x/base_y/base_dir   in   placement the trial is derived from
//   kind                     in   trial kind (LEFT/RIGHT/ROT/DOWN/DROP)
//   trial_x/trial_y/trial_dir out  candidate placement
//   forced                   out  trial leaves the board
// -----------------------------------------------------------------------------
module brick_trial_gen
    import brick_move_ctrl_pkg::*;
#(
    parameter int X_W   = X_W_DEF,
    parameter int Y_W   = Y_W_DEF,
    parameter int DIR_W = DIR_W_DEF,
    parameter int X_MAX = X_MAX_DEF
) (
    input  logic [X_W-1:0]   base_x,
    input  logic [Y_W-1:0]   base_y,
    input  logic [DIR_W-1:0] base_dir,
    input  kind_e            kind,
    output logic [X_W-1:0]   trial_x,
    output logic [Y_W-1:0]   trial_y,
    output logic [DIR_W-1:0] trial_dir,
    output logic             forced
);

    always_comb begin
        trial_x   = base_x;
        trial_y   = base_y;
        trial_dir = base_dir;
        forced    = 1'b0;
        case (kind)
            K_LEFT: begin
                trial_x = base_x - 1'b1;
                forced  = (base_x == '0);
            end
            K_RIGHT: begin
                trial_x = base_x + 1'b1;
                forced  = (base_x == X_W'(X_MAX));
            end
            K_ROT: begin
                trial_dir = base_dir + 1'b1;   // wraps modulo 2**DIR_W
            end
            K_DOWN, K_DROP: begin
                trial_y = base_y - 1'b1;
                forced  = (base_y == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/brick_move_ctrl.sv
// -----------------------------------------------------------------------------
// brick_move_ctrl
// Sequences the active brick of one game. Arbitrates key requests against the
// gravity tick, presents one trial placement per check to the shared
// collision checker, commits free trials, and on a blocked fall locks the
// brick, waits for the line clear and spawns the next brick.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start                          begin a game from IDLE
//   key_left/right/rot/down/drop   one-cycle move requests
//   grav_tick                      one-cycle gravity pulse (remembered)
//   next_type                      brick type used at the next spawn
//   try_pos/try_dir/try_type       trial placement to the collision checker
//   is_collided                    checker result for the try_* placement
//   cur_pos/cur_dir/cur_type       committed brick (type 0 = empty)
//   lock_req                       one-cycle: write cur_* into the board
//   clear_req / clear_done         line clear handshake
//   game_over                      sticky until rst
//   busy                           low only in READY
// -----------------------------------------------------------------------------
module brick_move_ctrl
    import brick_move_ctrl_pkg::*;
#(
    parameter int X_W     = X_W_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int X_MAX   = X_MAX_DEF,
    parameter int SPAWN_X = SPAWN_X_DEF,
    parameter int SPAWN_Y = SPAWN_Y_DEF,
    parameter int DIR_W   = DIR_W_DEF,
    parameter int TYPE_W  = TYPE_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 key_left,
    input  logic                 key_right,
    input  logic                 key_rot,
    input  logic                 key_down,
    input  logic                 key_drop,
    input  logic                 grav_tick,
    input  logic [TYPE_W-1:0]    next_type,
    output logic [X_W+Y_W-1:0]   try_pos,
    output logic [DIR_W-1:0]     try_dir,
    output logic [TYPE_W-1:0]    try_type,
    input  logic                 is_collided,
    output logic [X_W+Y_W-1:0]   cur_pos,
    output logic [DIR_W-1:0]     cur_dir,
    output logic [TYPE_W-1:0]    cur_type,
    output logic                 lock_req,
    output logic                 clear_req,
    input  logic                 clear_done,
    output logic                 game_over,
    output logic                 busy
);

    localparam logic [X_W-1:0] SPAWN_XV = X_W'(SPAWN_X);
    localparam logic [Y_W-1:0] SPAWN_YV = Y_W'(SPAWN_Y);

    state_e              state_q, state_d;
    kind_e               kind_q, kind_d, req_kind, gen_kind;
    logic [X_W-1:0]      cur_x_q, cur_x_d, try_x_q, try_x_d, base_x, gen_x;
    logic [Y_W-1:0]      cur_y_q, cur_y_d, try_y_q, try_y_d, base_y, gen_y;
    logic [DIR_W-1:0]    cur_dir_q, cur_dir_d, try_dir_q, try_dir_d, base_dir, gen_dir;
    logic [TYPE_W-1:0]   cur_type_q, cur_type_d, try_type_q, try_type_d;
    logic                forced_q, forced_d, gen_forced;
    logic                grav_pend_q, grav_pend_d;
    logic                collided;

    assign req_kind = pick_request(key_drop, key_rot, key_left, key_right,
                                   key_down, grav_pend_q);
    assign collided = forced_q | is_collided;

    // In CHECK the generator extends a hard drop from the trial just found
    // free; everywhere else it forms the trial from the committed brick.
    always_comb begin
        if (state_q == ST_CHECK) begin
            base_x   = try_x_q;
            base_y   = try_y_q;
            base_dir = try_dir_q;
            gen_kind = K_DROP;
        end else begin
            base_x   = cur_x_q;
            base_y   = cur_y_q;
            base_dir = cur_dir_q;
            gen_kind = req_kind;
        end
    end

    brick_trial_gen #(
        .X_W   (X_W),
        .Y_W   (Y_W),
        .DIR_W (DIR_W),
        .X_MAX (X_MAX)
    ) u_trial_gen (
        .base_x    (base_x),
        .base_y    (base_y),
        .base_dir  (base_dir),
        .kind      (gen_kind),
        .trial_x   (gen_x),
        .trial_y   (gen_y),
        .trial_dir (gen_dir),
        .forced    (gen_forced)
    );

    // State and placement registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            kind_q      <= K_NONE;
            cur_x_q     <= SPAWN_XV;
            cur_y_q     <= SPAWN_YV;
            cur_dir_q   <= '0;
            cur_type_q  <= '0;
            try_x_q     <= SPAWN_XV;
            try_y_q     <= SPAWN_YV;
            try_dir_q   <= '0;
            try_type_q  <= '0;
            forced_q    <= 1'b0;
            grav_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            cur_dir_q   <= cur_dir_d;
            cur_type_q  <= cur_type_d;
            try_x_q     <= try_x_d;
            try_y_q     <= try_y_d;
            try_dir_q   <= try_dir_d;
            try_type_q  <= try_type_d;
            forced_q    <= forced_d;
            grav_pend_q <= grav_pend_d;
        end
    end

    // Next-state and placement update
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        cur_dir_d   = cur_dir_q;
        cur_type_d  = cur_type_q;
        try_x_d     = try_x_q;
        try_y_d     = try_y_q;
        try_dir_d   = try_dir_q;
        try_type_d  = try_type_q;
        forced_d    = forced_q;
        grav_pend_d = grav_pend_q | grav_tick;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SPAWN;
            end
            ST_SPAWN: begin
                try_x_d    = SPAWN_XV;
                try_y_d    = SPAWN_YV;
                try_dir_d  = '0;
                try_type_d = next_type;
                kind_d     = K_SPAWN;
                forced_d   = 1'b0;
                state_d    = ST_CHECK;
            end
            ST_READY: begin
                if (req_kind != K_NONE) begin
                    try_x_d    = gen_x;
                    try_y_d    = gen_y;
                    try_dir_d  = gen_dir;
                    try_type_d = cur_type_q;
                    kind_d     = req_kind;
                    forced_d   = gen_forced;
                    state_d    = ST_CHECK;
                    // A key-down also absorbs any pending gravity step.
                    if (req_kind == K_DOWN) grav_pend_d = grav_tick;
                end
            end
            ST_CHECK: begin
                if (!collided) begin
                    cur_x_d    = try_x_q;
                    cur_y_d    = try_y_q;
                    cur_dir_d  = try_dir_q;
                    cur_type_d = try_type_q;
                    if (kind_q == K_DROP) begin
                        try_y_d  = gen_y;
                        forced_d = gen_forced;
                    end else begin
                        state_d = ST_READY;
                    end
                end else begin
                    case (kind_q)
                        K_DOWN, K_DROP: state_d = ST_LOCK;
                        K_SPAWN: begin
                            cur_type_d = try_type_q;
                            state_d    = ST_OVER;
                        end
                        default: state_d = ST_READY;
                    endcase
                end
            end
            ST_LOCK: begin
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (clear_done) state_d = ST_SPAWN;
            end
            ST_OVER: ;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        try_pos   = {try_x_q, try_y_q};
        try_dir   = try_dir_q;
        try_type  = try_type_q;
        cur_pos   = {cur_x_q, cur_y_q};
        cur_dir   = cur_dir_q;
        cur_type  = cur_type_q;
        lock_req  = (state_q == ST_LOCK);
        clear_req = (state_q == ST_CLEAR);
        game_over = (state_q == ST_OVER);
        busy      = (state_q != ST_READY);
    end

endmodule
